// File: rtl/loctag_seq.sv
`timescale 1ns/1ps
// loctag_seq: per start, warm the LT5534, take one ADC conversion (four averaged when
// LOCTAG_SEQ_AVG_EN is defined), and frequency-shift ctrl_1 for MOD_CYC cycles on a hit.
module loctag_seq #(
  parameter int              DW       = 12,
  parameter int              WARM_CYC = 100,
  parameter logic [DW-1:0]   THRESH   = 12'd512,
  parameter int              HALF_PER = 5,
  parameter int              MOD_CYC  = 50000,
  parameter int              PERIOD   = 500000,
  parameter int              ADC_TO   = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          trig,
  input  logic [1:0]    mode,
  input  logic          force_fs,
  output logic          adc_req,
  input  logic          adc_ack,
  input  logic [DW-1:0] adc_data,
  output logic          lt5534_en,
  output logic          ctrl_1,
  output logic          busy,
  output logic          led,
  output logic          adc_err
);

  localparam int WW = $clog2(WARM_CYC) + 1;
  localparam int TW = $clog2(ADC_TO) + 1;
  localparam int HW = $clog2(HALF_PER) + 1;
  localparam int MW = $clog2(MOD_CYC) + 1;
  localparam int PW = $clog2(PERIOD) + 1;

  localparam logic [WW-1:0] WARM_LAST = WW'(WARM_CYC - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(ADC_TO - 1);
  localparam logic [HW-1:0] HP_LAST   = HW'(HALF_PER - 1);
  localparam logic [MW-1:0] MOD_LAST  = MW'(MOD_CYC - 1);
  localparam logic [PW-1:0] PER_LAST  = PW'(PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WARMUP, S_SAMPLE, S_DECIDE, S_MODULATE, S_CONT
  } state_t;

  state_t        state_q, state_d;
  logic          trig_s1_q, trig_s1_d;
  logic          trig_s2_q, trig_s2_d;
  logic          trig_e_q, trig_e_d;
  logic [WW-1:0] warm_q, warm_d;
  logic [TW-1:0] to_q, to_d;
  logic [HW-1:0] hp_q, hp_d;
  logic [MW-1:0] mod_q, mod_d;
  logic [PW-1:0] per_q, per_d;
  logic          err_q, err_d;
  logic          lt_q, lt_d;
  logic          req_q, req_d;
  logic          ctrl_q, ctrl_d;
  logic          busy_q, busy_d;
  logic          led_q, led_d;
  logic          start_pls;
  logic          hit;

`ifdef LOCTAG_SEQ_AVG_EN
  logic [DW+1:0] sum_q, sum_d;
  logic [1:0]    nreq_q, nreq_d;
  assign hit = (sum_q[DW+1:2] >= THRESH);
`else
  logic [DW-1:0] sample_q, sample_d;
  assign hit = (sample_q >= THRESH);
`endif

  assign start_pls = trig_s2_q & ~trig_e_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      trig_s1_q <= 1'b0;
      trig_s2_q <= 1'b0;
      trig_e_q  <= 1'b0;
      warm_q    <= '0;
      to_q      <= '0;
      hp_q      <= '0;
      mod_q     <= '0;
      per_q     <= '0;
      err_q     <= 1'b0;
      lt_q      <= 1'b0;
      req_q     <= 1'b0;
      ctrl_q    <= 1'b0;
      busy_q    <= 1'b0;
      led_q     <= 1'b0;
`ifdef LOCTAG_SEQ_AVG_EN
      sum_q     <= '0;
      nreq_q    <= '0;
`else
      sample_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      trig_s1_q <= trig_s1_d;
      trig_s2_q <= trig_s2_d;
      trig_e_q  <= trig_e_d;
      warm_q    <= warm_d;
      to_q      <= to_d;
      hp_q      <= hp_d;
      mod_q     <= mod_d;
      per_q     <= per_d;
      err_q     <= err_d;
      lt_q      <= lt_d;
      req_q     <= req_d;
      ctrl_q    <= ctrl_d;
      busy_q    <= busy_d;
      led_q     <= led_d;
`ifdef LOCTAG_SEQ_AVG_EN
      sum_q     <= sum_d;
      nreq_q    <= nreq_d;
`else
      sample_q  <= sample_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    trig_s1_d = trig;
    trig_s2_d = trig_s1_q;
    trig_e_d  = trig_s2_q;
    warm_d    = warm_q;
    to_d      = to_q;
    mod_d     = mod_q;
    err_d     = err_q;
    per_d     = (per_q == PER_LAST) ? '0 : per_q + 1'b1;
`ifdef LOCTAG_SEQ_AVG_EN
    sum_d     = sum_q;
    nreq_d    = nreq_q;
`else
    sample_d  = sample_q;
`endif
    if (mode == 2'b00) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mode == 2'b11) begin
            state_d = S_CONT;
          end else if ((mode == 2'b10 && start_pls) || (mode == 2'b01 && per_q == PER_LAST)) begin
            state_d = S_WARMUP;
            warm_d  = '0;
          end
        end
        S_WARMUP: begin
          if (warm_q == WARM_LAST) begin
            state_d = S_SAMPLE;
            to_d    = '0;
`ifdef LOCTAG_SEQ_AVG_EN
            sum_d   = '0;
            nreq_d  = '0;
`endif
          end else begin
            warm_d = warm_q + 1'b1;
          end
        end
        S_SAMPLE: begin
          // An ack on the final timeout cycle still wins over the timeout.
          if (adc_ack) begin
`ifdef LOCTAG_SEQ_AVG_EN
            sum_d  = sum_q + {2'b00, adc_data};
            to_d   = '0;
            nreq_d = nreq_q + 1'b1;
            if (nreq_q == 2'd3) state_d = S_DECIDE;
`else
            sample_d = adc_data;
            state_d  = S_DECIDE;
`endif
          end else if (to_q == TO_LAST) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end else begin
            to_d = to_q + 1'b1;
          end
        end
        S_DECIDE: begin
          if (hit || force_fs) begin
            state_d = S_MODULATE;
            mod_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_MODULATE: begin
          if (mod_q == MOD_LAST) state_d = S_IDLE;
          else                   mod_d   = mod_q + 1'b1;
        end
        S_CONT: begin
          if (mode != 2'b11) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    lt_d   = (state_d == S_WARMUP) || (state_d == S_SAMPLE) || (state_d == S_DECIDE);
    req_d  = (state_d == S_SAMPLE);
    busy_d = (state_d != S_IDLE);
    led_d  = (state_d == S_MODULATE) || (state_d == S_CONT);
    ctrl_d = 1'b0;
    hp_d   = '0;
    // Shift starts high on entry, then flips every HALF_PER cycles while the state persists.
    if (led_d && state_d != state_q) begin
      ctrl_d = 1'b1;
    end else if (led_d) begin
      if (hp_q == HP_LAST) begin
        ctrl_d = ~ctrl_q;
      end else begin
        ctrl_d = ctrl_q;
        hp_d   = hp_q + 1'b1;
      end
    end
  end

  assign lt5534_en = lt_q;
  assign adc_req   = req_q;
  assign ctrl_1    = ctrl_q;
  assign busy      = busy_q;
  assign led       = led_q;
  assign adc_err   = err_q;

endmodule

// File: tb/tb_loctag_seq.sv
`timescale 1ns/1ps
// Randomized bench for loctag_seq; expected outputs come from a per-cycle timeline model.
module tb_loctag_seq;
  localparam int DW = 12, WARM = 4, HALF = 2, MODC = 16, PER = 64, TO = 8;
  localparam logic [DW-1:0] TH = 12'd512;
`ifdef LOCTAG_SEQ_AVG_EN
  localparam int NACK = 4;
`else
  localparam int NACK = 1;
`endif

  typedef struct packed {
    logic lt; logic req; logic ctrl; logic busy; logic led; logic err;
  } obs_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          trig = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic          force_fs = 1'b0;
  logic          adc_ack = 1'b0;
  logic [DW-1:0] adc_data = '0;
  logic          adc_req, lt5534_en, ctrl_1, busy, led, adc_err;

  int   n_checks = 0;
  int   n_fail = 0;
  int   ncyc = 0;
  logic err_model = 1'b0;

  loctag_seq #(.DW(DW), .WARM_CYC(WARM), .THRESH(TH), .HALF_PER(HALF),
               .MOD_CYC(MODC), .PERIOD(PER), .ADC_TO(TO)) dut (
    .clk(clk), .reset(reset), .trig(trig), .mode(mode), .force_fs(force_fs),
    .adc_req(adc_req), .adc_ack(adc_ack), .adc_data(adc_data),
    .lt5534_en(lt5534_en), .ctrl_1(ctrl_1), .busy(busy), .led(led), .adc_err(adc_err)
  );

  always #5 clk = ~clk;

  // Cycles since reset release: the period counter's phase by construction.
  always @(posedge clk) begin
    if (reset) ncyc <= 0;
    else       ncyc <= ncyc + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t observe();
    obs_t o;
    o = {lt5534_en, adc_req, ctrl_1, busy, led, adc_err};
    return o;
  endfunction

  // Expected outputs k cycles after trig rises; d = ack delay after adc_req (>= TO: never).
  function automatic obs_t model(int k, int d, bit hit, int abort_at, logic err_in);
    obs_t e;
    int s0, last, m;
    e = '0;
    e.err = err_in;
    s0 = 3 + WARM;
    if (abort_at >= 0 && k > abort_at) return e;
    if (k < 3) return e;
    if (k < s0) begin
      e.lt = 1'b1; e.busy = 1'b1;
      return e;
    end
    if (d >= TO) begin
      if (k < s0 + TO) begin
        e.lt = 1'b1; e.req = 1'b1; e.busy = 1'b1;
      end else begin
        e.err = 1'b1;
      end
      return e;
    end
    last = s0 + d + NACK - 1;
    if (k <= last) begin
      e.lt = 1'b1; e.req = 1'b1; e.busy = 1'b1;
    end else if (k == last + 1) begin
      e.lt = 1'b1; e.busy = 1'b1;
    end else begin
      m = k - last - 2;
      if (hit && m < MODC) begin
        e.busy = 1'b1; e.led = 1'b1;
        e.ctrl = ((m / HALF) % 2 == 0);
      end
    end
    return e;
  endfunction

  // fmode: 0 no force, 1 force whole run, 2 force everywhere except the DECIDE cycle.
  task automatic run_once(input string name, input int d, input logic [3:0][DW-1:0] dat,
                          input int fmode, input int abort_at);
    obs_t o, e;
    int   sum, last;
    bit   hit;
    sum = 0;
    for (int i = 0; i < NACK; i++) sum += dat[i];
    hit  = ((sum / NACK) >= TH) || (fmode == 1);
    last = 7 + d + NACK - 1;
    mode = 2'b10;
    for (int k = 0; k < 48; k++) begin
      trig     = (k < 2) || (k == 5);
      adc_ack  = 1'b0;
      adc_data = DW'($urandom);
      if (k == 4) begin
        adc_ack  = 1'b1;
        adc_data = 12'hFFF;
      end
      if (d < TO && k >= 7 + d && k <= last) begin
        adc_ack  = 1'b1;
        adc_data = dat[k - 7 - d];
      end
      force_fs = (fmode == 1) || (fmode == 2 && k != last + 1);
      if (abort_at >= 0 && k >= abort_at) mode = 2'b00;
      e = model(k, d, hit, abort_at, err_model);
      o = observe();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s cycle %0d: {lt,req,ctrl,busy,led,err} got %b want %b", name, k, o, e);
      end
      step();
    end
    if (d >= TO && abort_at < 0) err_model = 1'b1;
    trig = 1'b0; adc_ack = 1'b0; force_fs = 1'b0;
  endtask

  task automatic test_reset();
    obs_t o;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      o = observe();
      n_checks++;
      if (o !== '0) begin
        n_fail++;
        $display("FAIL reset_hold cycle %0d: got %b want 000000", i, o);
      end
    end
    reset = 1'b0;
    mode  = 2'b00;
    for (int i = 0; i < 100; i++) begin
      trig     = 1'($urandom);
      adc_ack  = 1'($urandom);
      force_fs = 1'($urandom);
      adc_data = DW'($urandom);
      step();
      o = observe();
      n_checks++;
      if (o !== '0) begin
        n_fail++;
        $display("FAIL mode_off cycle %0d: got %b want 000000", i, o);
      end
    end
    trig = 1'b0; adc_ack = 1'b0; force_fs = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_trigger();
    run_once("trig_600", 3, {4{12'd600}}, 0, -1);
  endtask

  task automatic test_threshold();
    run_once("thr_511", 2, {4{12'd511}}, 0, -1);
    run_once("thr_512", 0, {4{12'd512}}, 0, -1);
    run_once("force_511", 1, {4{12'd511}}, 1, -1);
    run_once("force_not_decide", 1, {4{12'd511}}, 2, -1);
  endtask

  task automatic test_timeout();
    run_once("ack_last_cycle", TO - 1, {4{12'd900}}, 0, -1);
    run_once("timeout", TO, {4{12'd900}}, 0, -1);
    run_once("after_timeout", 0, {4{12'd700}}, 0, -1);
  endtask

  task automatic test_random();
    logic [3:0][DW-1:0] dat;
    int d, fm;
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 4; i++)
        dat[i] = ($urandom_range(0, 1) == 1) ? DW'($urandom_range(490, 540)) : DW'($urandom);
      d  = $urandom_range(0, TO + 1);
      fm = ($urandom_range(0, 3) == 0) ? 1 : 0;
      run_once("random", d, dat, fm, -1);
    end
  endtask

  task automatic test_period();
    logic prev_lt, got, want;
    mode = 2'b01;
    prev_lt = lt5534_en;
    for (int k = 0; k < 300; k++) begin
      adc_ack  = adc_req;
      adc_data = 12'd700;
      trig     = (k == 100) || (k == 101) || (k == 150);
      if (k > 0) begin
        got  = lt5534_en && !prev_lt;
        want = (ncyc % PER == 0);
        n_checks++;
        if (got !== want) begin
          n_fail++;
          $display("FAIL period_entry cycle %0d phase %0d: got %b want %b", k, ncyc % PER, got, want);
        end
      end
      prev_lt = lt5534_en;
      step();
    end
    mode = 2'b00; adc_ack = 1'b0; trig = 1'b0;
    repeat (4) step();
  endtask

  task automatic cont_run(input logic [1:0] exit_mode, input int len);
    obs_t o, e;
    mode = 2'b11;
    for (int k = 0; k <= len + 1; k++) begin
      if (k == len) mode = exit_mode;
      e = '0;
      e.err = err_model;
      if (k >= 1 && k <= len) begin
        e.busy = 1'b1; e.led = 1'b1;
        e.ctrl = (((k - 1) / HALF) % 2 == 0);
      end
      o = observe();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL cont exit=%b cycle %0d: got %b want %b", exit_mode, k, o, e);
      end
      step();
    end
  endtask

  task automatic test_cont();
    cont_run(2'b00, 20);
    cont_run(2'b10, 7);
    run_once("abort_mod", 2, {4{12'd800}}, 0, 7 + 2 + NACK - 1 + 5);
  endtask

`ifdef LOCTAG_SEQ_AVG_EN
  task automatic test_avg();
    run_once("avg_550", 1, {12'd600, 12'd600, 12'd600, 12'd400}, 0, -1);
    run_once("avg_500", 0, {12'd600, 12'd600, 12'd400, 12'd400}, 0, -1);
  endtask
`endif

  initial begin
    test_reset();
    test_trigger();
    test_threshold();
    test_timeout();
    test_random();
    test_period();
    test_cont();
`ifdef LOCTAG_SEQ_AVG_EN
    test_avg();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
